// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample yields INTERP outputs, each a
// serial M-tap multiply-accumulate over the sample history.
//
// state   | meaning
// S_READ  | wait for an input sample, pop it into the history
// S_MAC   | one product per cycle over k = 0..M-1 for phase p
// S_WRITE | present y_out until the output FIFO accepts it
module fir_interp #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int INTERP     = 4,
    parameter logic [TAPS*DATA_WIDTH-1:0] COEFF = {
        32'hfffffffd, 32'hfffffffa, 32'hfffffff7, 32'hfffffff5,
        32'hfffffff4, 32'hfffffff6, 32'hfffffff8, 32'hfffffff3,
        32'h00000014, 32'h0000002d, 32'h0000005a, 32'h00000096,
        32'h000000e6, 32'h00000140, 32'h000001a4, 32'h00000243,
        32'h00000243, 32'h000001a4, 32'h00000140, 32'h000000e6,
        32'h00000096, 32'h0000005a, 32'h0000002d, 32'h00000014,
        32'hfffffff3, 32'hfffffff8, 32'hfffffff6, 32'hfffffff4,
        32'hfffffff5, 32'hfffffff7, 32'hfffffffa, 32'hfffffffd
    },
    parameter int QUANT_BITS = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic                         x_empty,
    output logic                         x_rd_en,
    output logic signed [DATA_WIDTH-1:0] y_out,
    input  logic                         y_out_full,
    output logic                         y_wr_en
);

    localparam int M  = TAPS / INTERP;
    localparam int PW = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(INTERP - 1);
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);

    localparam logic [1:0] S_READ  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]                   state;
    logic [PW-1:0]                p;
    logic [KW-1:0]                k;
    logic signed [DATA_WIDTH-1:0] hist [M];
    logic signed [DATA_WIDTH-1:0] acc;

    logic signed [DATA_WIDTH-1:0]   h_rom [TAPS];
    logic [IW-1:0]                  coef_idx;
    logic signed [2*DATA_WIDTH-1:0] prod_full;
    logic signed [DATA_WIDTH-1:0]   prod;
    logic signed [DATA_WIDTH-1:0]   acc_base;
    logic signed [DATA_WIDTH-1:0]   acc_next;

    // h[0] is the most significant word of COEFF
    for (genvar i = 0; i < TAPS; i++) begin : g_rom
        assign h_rom[i] = COEFF[(TAPS-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign coef_idx  = IW'(p) + IW'(k) * IW'(INTERP);
    assign prod_full = h_rom[coef_idx] * hist[k];
    assign prod      = DATA_WIDTH'(prod_full >>> QUANT_BITS);
    assign acc_base  = (k == '0) ? '0 : acc;
    assign acc_next  = acc_base + prod;

    // Reset gating keeps both strobes low while reset is asserted
    assign x_rd_en = reset && (state == S_READ)  && !x_empty;
    assign y_wr_en = reset && (state == S_WRITE) && !y_out_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_READ;
            p     <= '0;
            k     <= '0;
            acc   <= '0;
            y_out <= '0;
            for (int i = 0; i < M; i++) begin
                hist[i] <= '0;
            end
        end else begin
            case (state)
                S_READ: begin
                    if (!x_empty) begin
                        for (int i = M - 1; i > 0; i--) begin
                            hist[i] <= hist[i-1];
                        end
                        hist[0] <= x_in;
                        p       <= '0;
                        k       <= '0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (k == K_LAST) begin
                        y_out <= acc_next;
                        k     <= '0;
                        state <= S_WRITE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_WRITE: begin
                    if (!y_out_full) begin
                        if (p == P_LAST) begin
                            state <= S_READ;
                        end else begin
                            p     <= p + PW'(1);
                            state <= S_MAC;
                        end
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: FIFO models on both sides, table of impulse
// style vectors plus backpressure, starvation and reset-mid-MAC sequences.
module tb_fir_interp;

    localparam logic [31:0] H_TAB [32] = '{
        32'hfffffffd, 32'hfffffffa, 32'hfffffff7, 32'hfffffff5,
        32'hfffffff4, 32'hfffffff6, 32'hfffffff8, 32'hfffffff3,
        32'h00000014, 32'h0000002d, 32'h0000005a, 32'h00000096,
        32'h000000e6, 32'h00000140, 32'h000001a4, 32'h00000243,
        32'h00000243, 32'h000001a4, 32'h00000140, 32'h000000e6,
        32'h00000096, 32'h0000005a, 32'h0000002d, 32'h00000014,
        32'hfffffff3, 32'hfffffff8, 32'hfffffff6, 32'hfffffff4,
        32'hfffffff5, 32'hfffffff7, 32'hfffffffa, 32'hfffffffd
    };
    localparam int NOUT = 40;

    typedef struct {
        string                  name;
        logic [31:0]            x0;
        logic [31:0]            x1;
        logic [NOUT-1:0][31:0]  exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] x_in = '0;
    logic        x_empty = 1'b1;
    logic        x_rd_en;
    logic [31:0] y_out;
    logic        y_out_full = 1'b0;
    logic        y_wr_en;

    logic [31:0] in_q [$];
    logic [31:0] wr_q [$];
    int          cyc = 0;
    int          rd_cnt = 0;
    int          first_rd = -1;
    int          first_wr = -1;
    logic        rd_pend = 1'b0;
    logic        both_seen = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vecs [4];

    fir_interp dut (
        .clock      (clock),
        .reset      (reset),
        .x_in       (x_in),
        .x_empty    (x_empty),
        .x_rd_en    (x_rd_en),
        .y_out      (y_out),
        .y_out_full (y_out_full),
        .y_wr_en    (y_wr_en)
    );

    initial forever #5 clock = ~clock;

    // Input FIFO model: the pop decided at the previous falling edge lands here
    always @(posedge clock) begin
        cyc++;
        #1;
        if (rd_pend && in_q.size() > 0) void'(in_q.pop_front());
        rd_pend = 1'b0;
        x_empty = (in_q.size() == 0);
        x_in    = x_empty ? 32'h0 : in_q[0];
    end

    always @(negedge clock) begin
        rd_pend = x_rd_en;
        if (x_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (y_wr_en) begin
            wr_q.push_back(y_out);
            if (first_wr < 0) first_wr = cyc;
        end
        if (x_rd_en && y_wr_en) both_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        y_out_full = 1'b0;
        in_q.delete();
        repeat (2) tick();
        wr_q.delete();
        rd_cnt = 0;
        first_rd = -1;
        first_wr = -1;
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int t = 0;
        while (wr_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (wr_q.size() < n) check("write_timeout", 32'(wr_q.size()), 32'(n));
    endtask

    task automatic run_vec(input int v, input logic check_lat);
        int c_push;
        logic [31:0] act;
        wr_q.delete();
        rd_cnt = 0;
        first_rd = -1;
        first_wr = -1;
        in_q.push_back(vecs[v].x0);
        in_q.push_back(vecs[v].x1);
        for (int i = 0; i < 8; i++) in_q.push_back(32'h0);
        c_push = cyc;
        wait_writes(NOUT, 800);
        if (check_lat) begin
            check("first_rd_cycle", 32'(first_rd - c_push), 32'd1);
            check("rd_to_wr_latency", 32'(first_wr - first_rd), 32'd9);
        end
        for (int j = 0; j < NOUT; j++) begin
            act = (j < wr_q.size()) ? wr_q[j] : 32'hdeadbeef;
            check($sformatf("%s[%0d]", vecs[v].name, j), act, vecs[v].exp[j]);
        end
        repeat (20) tick();
        check({vecs[v].name, "_write_count"}, 32'(wr_q.size()), 32'(NOUT));
        check({vecs[v].name, "_read_count"}, 32'(rd_cnt), 32'd10);
    endtask

    initial begin
        logic [31:0] held;

        // Vector table: impulse, negative impulse, truncation, two-sample overlap
        vecs[0].name = "impulse";  vecs[0].x0 = 32'h00000400; vecs[0].x1 = 32'h0;
        vecs[1].name = "neg_imp";  vecs[1].x0 = 32'hfffffc00; vecs[1].x1 = 32'h0;
        vecs[2].name = "trunc";    vecs[2].x0 = 32'h00000001; vecs[2].x1 = 32'h0;
        vecs[3].name = "pair";     vecs[3].x0 = 32'h00000400; vecs[3].x1 = 32'h00000800;
        for (int i = 0; i < NOUT; i++) begin
            vecs[0].exp[i] = (i < 32) ? H_TAB[i] : 32'h0;
            vecs[1].exp[i] = (i < 32) ? 32'h0 - H_TAB[i] : 32'h0;
            vecs[2].exp[i] = (i < 32 && H_TAB[i][31]) ? 32'hffffffff : 32'h0;
            vecs[3].exp[i] = ((i < 32) ? H_TAB[i] : 32'h0)
                           + ((i >= 4 && i < 36) ? {H_TAB[i-4][30:0], 1'b0} : 32'h0);
        end

        // Reset state with a sample waiting: strobes must stay low
        in_q.push_back(32'h00001234);
        repeat (2) tick();
        check("rst_x_rd_en", {31'b0, x_rd_en}, 32'd0);
        check("rst_y_wr_en", {31'b0, y_wr_en}, 32'd0);
        check("rst_y_out", y_out, 32'h0);

        for (int v = 0; v < 4; v++) begin
            reset_dut();
            run_vec(v, v == 0);
        end

        // Backpressure at the first write
        reset_dut();
        y_out_full = 1'b1;
        in_q.push_back(32'h00000400);
        for (int i = 0; i < 9; i++) in_q.push_back(32'h0);
        repeat (20) tick();
        for (int i = 0; i < 20; i++) begin
            check("bp_y_wr_en", {31'b0, y_wr_en}, 32'd0);
            check("bp_x_rd_en", {31'b0, x_rd_en}, 32'd0);
            check("bp_y_out", y_out, H_TAB[0]);
            tick();
        end
        check("bp_no_writes", 32'(wr_q.size()), 32'd0);
        check("bp_one_read", 32'(rd_cnt), 32'd1);
        y_out_full = 1'b0;
        tick();
        check("bp_release_one_write", 32'(wr_q.size()), 32'd1);
        wait_writes(NOUT, 800);
        for (int j = 0; j < NOUT; j++) begin
            held = (j < wr_q.size()) ? wr_q[j] : 32'hdeadbeef;
            check($sformatf("bp_seq[%0d]", j), held, vecs[0].exp[j]);
        end

        // Starvation after a single sample
        reset_dut();
        in_q.push_back(32'h00000400);
        repeat (90) tick();
        check("starve_writes", 32'(wr_q.size()), 32'd4);
        check("starve_reads", 32'(rd_cnt), 32'd1);
        check("starve_x_rd_en", {31'b0, x_rd_en}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            held = (j < wr_q.size()) ? wr_q[j] : 32'hdeadbeef;
            check($sformatf("starve_y[%0d]", j), held, H_TAB[j]);
        end

        // Reset at k=3 of input 2
        reset_dut();
        for (int i = 0; i < 8; i++) in_q.push_back(32'h00000400);
        begin
            int t = 0;
            while (rd_cnt < 3 && t < 200) begin
                tick();
                t++;
            end
        end
        check("rm_reached_input2", 32'(rd_cnt), 32'd3);
        repeat (3) tick();
        check("rm_writes_before", 32'(wr_q.size()), 32'd8);
        check("rm_y_out_before", y_out, H_TAB[7] + H_TAB[3]);
        reset = 1'b0;
        #1;
        check("rm_y_out", y_out, 32'h0);
        check("rm_x_rd_en", {31'b0, x_rd_en}, 32'd0);
        check("rm_y_wr_en", {31'b0, y_wr_en}, 32'd0);
        in_q.delete();
        repeat (2) tick();
        wr_q.delete();
        reset = 1'b1;
        repeat (30) tick();
        check("rm_no_stale_write", 32'(wr_q.size()), 32'd0);
        run_vec(0, 1'b1);

        check("rd_wr_exclusive", {31'b0, both_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
